// File: rtl/mole_field_if.sv
// ============================================================================
// mole_field_if : game-side signal bundle of mole_field_ctrl
//                 (round strobe, enable, buttons in; LEDs, pulses, counters out)
// Revision      : 1.0
// ============================================================================
`default_nettype none

interface mole_field_if #(
  parameter int N_CH    = 8,
  parameter int SCORE_W = 8
);
  logic                i_tick;
  logic                i_enable;
  logic [N_CH-1:0]     i_btn_n;
  logic [N_CH-1:0]     o_led;
  logic                o_hit_pulse;
  logic                o_miss_pulse;
  logic [SCORE_W-1:0]  o_score;
  logic [SCORE_W-1:0]  o_escapes;
  logic [7:0]          o_round_idx;
  logic                o_game_over;

  modport slave (
    input  i_tick, i_enable, i_btn_n,
    output o_led, o_hit_pulse, o_miss_pulse, o_score, o_escapes,
           o_round_idx, o_game_over
  );

  modport master (
    output i_tick, i_enable, i_btn_n,
    input  o_led, o_hit_pulse, o_miss_pulse, o_score, o_escapes,
           o_round_idx, o_game_over
  );
endinterface

`default_nettype wire

// File: rtl/mole_field_ctrl.sv
// ============================================================================
// mole_field_ctrl : hit-the-lit-LED game controller with LFSR patterns and
//                   saturating score/escape counters. Optional wrong-press
//                   penalty enabled by defining MOLE_PENALTY_EN.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module mole_field_ctrl #(
  parameter int                N_CH      = 8,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 'hACE1,
  parameter int                ROUNDS    = 16,
  parameter int                SCORE_W   = 8
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  mole_field_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LIVE = 2'd1, S_DONE = 2'd2} state_t;

  localparam int                c_AW        = SCORE_W + 6;
  localparam logic [LFSR_W-1:0] c_TAPS      = LFSR_W'(16'hB400);
  localparam logic [7:0]        c_ROUNDS    = 8'(ROUNDS);
  localparam logic [SCORE_W-1:0] c_SCORE_MAX = '1;

  state_t              r_state, w_state_nx;
  logic [N_CH-1:0]     r_s1, r_s2, r_s3, r_press;
  logic [LFSR_W-1:0]   r_lfsr, w_lfsr_nx, w_lfsr_step;
  logic [N_CH-1:0]     r_led, w_led_nx, w_hit, w_pattern, w_slice;
  logic                r_hit_pulse, w_hit_pulse_nx;
  logic                r_miss_pulse, w_miss_pulse_nx, w_miss;
  logic [SCORE_W-1:0]  r_score, w_score_nx, w_score_sat;
  logic [SCORE_W-1:0]  r_esc, w_esc_nx, w_esc_sat;
  logic [7:0]          r_round, w_round_nx, w_round_inc;
  logic [4:0]          w_hit_cnt, w_esc_cnt, w_pen_cnt;
  logic signed [c_AW-1:0] w_score_sum;
  logic [c_AW-1:0]     w_esc_sum;

  function automatic logic [4:0] f_popcount(input logic [N_CH-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < N_CH; i++) n = n + 5'(v[i]);
    return n;
  endfunction

  // Buttons: 2-FF sync, then a registered falling-edge (press) detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= '1;
      r_s2    <= '1;
      r_s3    <= '1;
      r_press <= '0;
    end else begin
      r_s1    <= bus.i_btn_n;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_press <= r_s3 & ~r_s2;
    end
  end

  assign w_hit       = r_press & r_led;
  assign w_hit_cnt   = f_popcount(w_hit);
  assign w_esc_cnt   = f_popcount(r_led & ~w_hit);
  assign w_lfsr_step = (r_lfsr >> 1) ^ (r_lfsr[0] ? c_TAPS : '0);
  assign w_slice     = w_lfsr_step[N_CH-1:0];
  assign w_pattern   = (w_slice == '0) ? N_CH'(1) : w_slice;
  assign w_round_inc = r_round + 8'd1;

`ifdef MOLE_PENALTY_EN
  logic [N_CH-1:0] w_wrong;
  assign w_wrong   = r_press & ~r_led;
  assign w_pen_cnt = f_popcount(w_wrong);
  assign w_miss    = |w_wrong;
`else
  assign w_pen_cnt = '0;
  assign w_miss    = 1'b0;
`endif

  // Hits and penalties net out before clamping to 0..max
  assign w_score_sum = $signed(c_AW'(r_score)) + $signed(c_AW'(w_hit_cnt))
                     - $signed(c_AW'(w_pen_cnt));
  assign w_esc_sum   = c_AW'(r_esc) + c_AW'(w_esc_cnt);

  always_comb begin
    w_score_sat = w_score_sum[SCORE_W-1:0];
    if (w_score_sum[c_AW-1])
      w_score_sat = '0;
    else if (w_score_sum > $signed(c_AW'(c_SCORE_MAX)))
      w_score_sat = c_SCORE_MAX;
    w_esc_sat = (w_esc_sum > c_AW'(c_SCORE_MAX)) ? c_SCORE_MAX : w_esc_sum[SCORE_W-1:0];
  end

  always_comb begin
    w_state_nx      = r_state;
    w_lfsr_nx       = r_lfsr;
    w_led_nx        = r_led;
    w_hit_pulse_nx  = 1'b0;
    w_miss_pulse_nx = 1'b0;
    w_score_nx      = r_score;
    w_esc_nx        = r_esc;
    w_round_nx      = r_round;
    if (!bus.i_enable) begin
      w_state_nx = S_IDLE;
      w_led_nx   = '1;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nx = S_LIVE;
          w_led_nx   = '0;
          w_score_nx = '0;
          w_esc_nx   = '0;
          w_round_nx = '0;
        end
        S_LIVE: begin
          w_hit_pulse_nx  = |w_hit;
          w_miss_pulse_nx = w_miss;
          w_score_nx      = w_score_sat;
          w_led_nx        = r_led & ~w_hit;
          // Hits are credited against the old pattern before a tick replaces it
          if (bus.i_tick) begin
            w_esc_nx   = w_esc_sat;
            w_round_nx = w_round_inc;
            w_lfsr_nx  = w_lfsr_step;
            if (w_round_inc == c_ROUNDS) begin
              w_state_nx = S_DONE;
              w_led_nx   = '0;
            end else begin
              w_led_nx = w_pattern;
            end
          end
        end
        S_DONE:  w_led_nx = '0;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_lfsr       <= LFSR_SEED;
      r_led        <= '1;
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
      r_score      <= '0;
      r_esc        <= '0;
      r_round      <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_lfsr       <= w_lfsr_nx;
      r_led        <= w_led_nx;
      r_hit_pulse  <= w_hit_pulse_nx;
      r_miss_pulse <= w_miss_pulse_nx;
      r_score      <= w_score_nx;
      r_esc        <= w_esc_nx;
      r_round      <= w_round_nx;
    end
  end

  assign bus.o_led        = r_led;
  assign bus.o_hit_pulse  = r_hit_pulse;
  assign bus.o_miss_pulse = r_miss_pulse;
  assign bus.o_score      = r_score;
  assign bus.o_escapes    = r_esc;
  assign bus.o_round_idx  = r_round;
  assign bus.o_game_over  = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_mole_field_ctrl.sv
// ============================================================================
// tb_mole_field_ctrl : directed self-checking bench for mole_field_ctrl
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_mole_field_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

`ifdef MOLE_PENALTY_EN
  localparam logic       EXP_MISS = 1'b1;
  localparam logic [7:0] EXP_S1   = 8'd0;
  localparam logic [7:0] EXP_S2   = 8'd0;
`else
  localparam logic       EXP_MISS = 1'b0;
  localparam logic [7:0] EXP_S1   = 8'd1;
  localparam logic [7:0] EXP_S2   = 8'd1;
`endif

  always #5 clk = ~clk;

  mole_field_if #(.N_CH(8), .SCORE_W(8)) bus1 ();
  mole_field_if #(.N_CH(8), .SCORE_W(8)) bus2 ();

  mole_field_ctrl #(.N_CH(8), .LFSR_W(16), .LFSR_SEED(16'hACE1), .ROUNDS(16), .SCORE_W(8))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  mole_field_ctrl #(.N_CH(8), .LFSR_W(16), .LFSR_SEED(16'hACE1), .ROUNDS(2), .SCORE_W(8))
    u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick1();
    bus1.i_tick = 1'b1; step(1); bus1.i_tick = 1'b0;
  endtask

  task automatic restart1();
    rst_n = 1'b0; step(1); rst_n = 1'b1;
    bus1.i_enable = 1'b1; bus1.i_btn_n = 8'hFF; step(1);
    tick1();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus1.i_tick = 1'b0; bus1.i_enable = 1'b0; bus1.i_btn_n = 8'hFF;
    bus2.i_tick = 1'b0; bus2.i_enable = 1'b0; bus2.i_btn_n = 8'hFF;
    step(2);
    checks++; if (bus1.o_led !== 8'hFF) begin errors++; $display("FAIL reset_led got %h want ff", bus1.o_led); end
    checks++; if (bus1.o_score !== 8'd0 || bus1.o_escapes !== 8'd0 || bus1.o_round_idx !== 8'd0) begin
      errors++; $display("FAIL reset_counters got %0d/%0d/%0d want 0/0/0", bus1.o_score, bus1.o_escapes, bus1.o_round_idx); end
    checks++; if ({bus1.o_game_over, bus1.o_hit_pulse, bus1.o_miss_pulse} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b want 000", {bus1.o_game_over, bus1.o_hit_pulse, bus1.o_miss_pulse}); end
    checks++; if (bus2.o_led !== 8'hFF) begin errors++; $display("FAIL reset_led2 got %h want ff", bus2.o_led); end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_rounds();
    bus1.i_enable = 1'b1; step(1);
    checks++; if (bus1.o_led !== 8'h00) begin errors++; $display("FAIL entry_led got %h want 00", bus1.o_led); end
    tick1();
    checks++; if (bus1.o_led !== 8'h70) begin errors++; $display("FAIL tick1_led got %h want 70", bus1.o_led); end
    checks++; if (bus1.o_round_idx !== 8'd1) begin errors++; $display("FAIL tick1_round got %0d want 1", bus1.o_round_idx); end
    tick1();
    checks++; if (bus1.o_led !== 8'h38) begin errors++; $display("FAIL tick2_led got %h want 38", bus1.o_led); end
    checks++; if (bus1.o_round_idx !== 8'd2) begin errors++; $display("FAIL tick2_round got %0d want 2", bus1.o_round_idx); end
    checks++; if (bus1.o_escapes !== 8'd3) begin errors++; $display("FAIL tick2_esc got %0d want 3", bus1.o_escapes); end
  endtask

  task automatic test_hit();
    restart1();
    bus1.i_btn_n = 8'hEF; step(3);
    checks++; if (bus1.o_led !== 8'h70 || bus1.o_hit_pulse !== 1'b0) begin
      errors++; $display("FAIL hit_early got led %h pulse %b want 70 0", bus1.o_led, bus1.o_hit_pulse); end
    step(1);
    checks++; if (bus1.o_led !== 8'h60) begin errors++; $display("FAIL hit_led got %h want 60", bus1.o_led); end
    checks++; if (bus1.o_hit_pulse !== 1'b1) begin errors++; $display("FAIL hit_pulse got %b want 1", bus1.o_hit_pulse); end
    checks++; if (bus1.o_score !== 8'd1) begin errors++; $display("FAIL hit_score got %0d want 1", bus1.o_score); end
    step(1);
    checks++; if (bus1.o_hit_pulse !== 1'b0) begin errors++; $display("FAIL hit_pulse_len got %b want 0", bus1.o_hit_pulse); end
    step(4);
    checks++; if (bus1.o_score !== 8'd1) begin errors++; $display("FAIL hold_score got %0d want 1", bus1.o_score); end
    bus1.i_btn_n = 8'hFF; step(3);
  endtask

  task automatic test_tick_and_hit();
    restart1();
    bus1.i_btn_n = 8'hEF; step(3);
    tick1();
    checks++; if (bus1.o_score !== 8'd1) begin errors++; $display("FAIL th_score got %0d want 1", bus1.o_score); end
    checks++; if (bus1.o_led !== 8'h38) begin errors++; $display("FAIL th_led got %h want 38", bus1.o_led); end
    checks++; if (bus1.o_escapes !== 8'd2) begin errors++; $display("FAIL th_esc got %0d want 2", bus1.o_escapes); end
    checks++; if (bus1.o_hit_pulse !== 1'b1 || bus1.o_round_idx !== 8'd2) begin
      errors++; $display("FAIL th_pulse_round got %b/%0d want 1/2", bus1.o_hit_pulse, bus1.o_round_idx); end
  endtask

  task automatic test_wrong_press();
    bus1.i_btn_n = 8'hFF; step(3);
    bus1.i_btn_n = 8'hFE; step(3);
    checks++; if (bus1.o_miss_pulse !== 1'b0) begin errors++; $display("FAIL miss_early got %b want 0", bus1.o_miss_pulse); end
    step(1);
    checks++; if (bus1.o_miss_pulse !== EXP_MISS) begin errors++; $display("FAIL miss_pulse got %b want %b", bus1.o_miss_pulse, EXP_MISS); end
    checks++; if (bus1.o_score !== EXP_S1) begin errors++; $display("FAIL miss_score1 got %0d want %0d", bus1.o_score, EXP_S1); end
    checks++; if (bus1.o_led !== 8'h38) begin errors++; $display("FAIL miss_led got %h want 38", bus1.o_led); end
    step(1);
    checks++; if (bus1.o_miss_pulse !== 1'b0) begin errors++; $display("FAIL miss_len got %b want 0", bus1.o_miss_pulse); end
    bus1.i_btn_n = 8'hFF; step(3);
    bus1.i_btn_n = 8'hFE; step(4);
    checks++; if (bus1.o_score !== EXP_S2) begin errors++; $display("FAIL miss_score2 got %0d want %0d", bus1.o_score, EXP_S2); end
    bus1.i_btn_n = 8'hFF;
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus1.o_led !== 8'hFF) begin errors++; $display("FAIL areset_led got %h want ff", bus1.o_led); end
    checks++; if (bus1.o_score !== 8'd0 || bus1.o_escapes !== 8'd0 || bus1.o_round_idx !== 8'd0) begin
      errors++; $display("FAIL areset_counters got %0d/%0d/%0d want 0/0/0", bus1.o_score, bus1.o_escapes, bus1.o_round_idx); end
    step(1);
    rst_n = 1'b1;
  endtask

  task automatic test_enable_override();
    bus1.i_enable = 1'b1; step(1);
    tick1();
    checks++; if (bus1.o_led !== 8'h70) begin errors++; $display("FAIL ov_led_pre got %h want 70", bus1.o_led); end
    bus1.i_enable = 1'b0;
    tick1();
    checks++; if (bus1.o_led !== 8'hFF) begin errors++; $display("FAIL ov_led got %h want ff", bus1.o_led); end
    checks++; if (bus1.o_round_idx !== 8'd1 || bus1.o_escapes !== 8'd0) begin
      errors++; $display("FAIL ov_round_esc got %0d/%0d want 1/0", bus1.o_round_idx, bus1.o_escapes); end
  endtask

  task automatic test_done();
    bus2.i_enable = 1'b1; step(1);
    bus2.i_tick = 1'b1; step(1); bus2.i_tick = 1'b0;
    checks++; if (bus2.o_led !== 8'h70) begin errors++; $display("FAIL d_led1 got %h want 70", bus2.o_led); end
    bus2.i_btn_n = 8'hEF; step(4);
    checks++; if (bus2.o_score !== 8'd1 || bus2.o_led !== 8'h60) begin
      errors++; $display("FAIL d_hit got %0d/%h want 1/60", bus2.o_score, bus2.o_led); end
    bus2.i_btn_n = 8'hFF;
    bus2.i_tick = 1'b1; step(1); bus2.i_tick = 1'b0;
    checks++; if (bus2.o_game_over !== 1'b1 || bus2.o_led !== 8'h00) begin
      errors++; $display("FAIL d_over got %b/%h want 1/00", bus2.o_game_over, bus2.o_led); end
    checks++; if (bus2.o_round_idx !== 8'd2 || bus2.o_escapes !== 8'd2) begin
      errors++; $display("FAIL d_round_esc got %0d/%0d want 2/2", bus2.o_round_idx, bus2.o_escapes); end
    step(2);
    checks++; if (bus2.o_game_over !== 1'b1 || bus2.o_led !== 8'h00) begin
      errors++; $display("FAIL d_hold got %b/%h want 1/00", bus2.o_game_over, bus2.o_led); end
    bus2.i_enable = 1'b0; step(1);
    checks++; if (bus2.o_led !== 8'hFF || bus2.o_score !== 8'd1 || bus2.o_game_over !== 1'b0) begin
      errors++; $display("FAIL d_idle got %h/%0d/%b want ff/1/0", bus2.o_led, bus2.o_score, bus2.o_game_over); end
    bus2.i_enable = 1'b1; step(1);
    checks++; if (bus2.o_score !== 8'd0 || bus2.o_led !== 8'h00 || bus2.o_round_idx !== 8'd0) begin
      errors++; $display("FAIL d_restart got %0d/%h/%0d want 0/00/0", bus2.o_score, bus2.o_led, bus2.o_round_idx); end
  endtask

  initial begin
    test_reset();
    test_rounds();
    test_hit();
    test_tick_and_hit();
    test_wrong_press();
    test_async_reset();
    test_enable_override();
    test_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/mole_field_ctrl.md
# mole_field_ctrl

Parametrised hit-the-lit-LED game controller for the LED counter board. It replaces the fixed 8-LED controller with a single-clock design: round strobe as an enable, N channels, synchronised and edge-detected buttons, and a round-limited game FSM. It adds saturating score and escape counters and a deterministic LFSR pattern source. It sits between the board button bank and the LED driver and feeds the score display counter.

## Interface
- N_CH, 8: number of LED/button channels, 1..16.
- LFSR_W, 16: pattern LFSR width; must be ≥ N_CH. Galois form, right shift, tap mask 16'hB400.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be non-zero.
- ROUNDS, 16: number of ticks per game, 1..255.
- SCORE_W, 8: width of the score and escape counters.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- tick  in  1  round strobe, one clk wide, synchronous to clk.
- enable  in  1  game enable, level-sensitive.
- btn_n  in  N_CH  raw buttons, active-low, asynchronous.
- led  out  N_CH  1 = LED lit.
- hit_pulse  out  1  one-cycle pulse when at least one lit LED is struck.
- miss_pulse  out  1  one-cycle pulse on a press of an unlit LED.
- score  out  SCORE_W  saturating hit count.
- escapes  out  SCORE_W  saturating count of lit LEDs not struck before their round ended.
- round_idx  out  8  rounds completed in the current game.
- game_over  out  1  high in the DONE state.

## Operation
- Button path: 2-FF synchroniser per bit, then inversion, then rising-edge detect. The result is press[i], a one-cycle event.
- FSM states:
  - IDLE (reset state): led = all ones (lamp test).
  - IDLE→LIVE on enable=1. Entry clears score, escapes and round_idx, and clears led to 0.
  - LIVE: on tick, advance the LFSR one step and load led = lfsr_next[N_CH-1:0]. If that slice is 0, load 1 on bit 0.
  - LIVE→DONE when round_idx reaches ROUNDS on a tick. That tick increments round_idx and counts escapes but loads no new pattern. led = 0 in DONE.
  - Any state→IDLE when enable=0. score and escapes hold their values; led returns to all ones.
- Hits, in LIVE only:
  - hit = press & led.
  - led &= ~hit.
  - score += popcount(hit), saturating at 2^SCORE_W-1.
  - hit_pulse = |hit.
- Misses, in LIVE only: wrong = press & ~led. See Configuration.
- Escapes: on each tick in LIVE, escapes += popcount(led & ~hit), saturating.
- Tick and press in the same cycle: hits are judged against the current pattern and credited first; the new pattern then overwrites led.
- Presses in IDLE and DONE are ignored. The LFSR advances only on tick in LIVE, so the sequence is reproducible from reset.

## Timing
- Reset values:
  - led = all ones.
  - hit_pulse, miss_pulse, game_over = 0.
  - score, escapes, round_idx = 0.
  - LFSR = LFSR_SEED.
  - FSM in IDLE.
  - Synchroniser flops = 1 (released).
- Press latency: btn_n falls before clk edge k. The hit is registered (led bit clears, hit_pulse high) at edge k+3. hit_pulse lasts exactly one cycle.
- Pattern load: led updates at the same edge that samples tick=1.
- Holding a button produces one event only. Re-pressing requires release followed by 2 synchroniser cycles.
- enable deassertion mid-round takes effect at the next edge and overrides a simultaneous tick or press.
- rst_n assertion mid-game forces reset values asynchronously.

## Configuration
- MOLE_PENALTY_EN defined:
  - In LIVE, |wrong pulses miss_pulse for one cycle.
  - score decrements by popcount(wrong), floored at 0.
  - If hits and wrong presses occur in the same cycle, score changes by the net value, clamped to the range 0..max.
- MOLE_PENALTY_EN undefined: miss_pulse is tied to 0 and wrong presses have no effect.

## Test plan
- Reset, enable=1, one tick → led = 8'h70 (LFSR 16'hE270); second tick → led = 8'h38, round_idx = 2, escapes = 3 (the bits of 8'h70).
- led = 8'h70, press btn_n[4] low → 3 cycles later led = 8'h60, hit_pulse for one cycle, score = 1; holding the button gives no further credit.
- Press on bit 4 and tick sampled at the same edge → score +1, led = 8'h38, escapes counts only bits 5 and 6 (+2).
- With MOLE_PENALTY_EN: score = 1, press unlit bit 0 → miss_pulse, score = 0; repeat → score stays 0.
- ROUNDS = 2 → after 2 ticks game_over = 1, led = 0; enable=0 → led = 8'hFF, score held; enable=1 → score = 0.
- rst_n low mid-game → led = 8'hFF and all counters 0 immediately, without a clock.
